// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one FIFO push port among NUM_REQ requesters,
// with a one-entry output stage. Optional per-requester push counters: FIFO_PUSH_ARB_STATS_EN.
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 17,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            grant_out,
    output logic                            valid_in,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic [$clog2(NUM_REQ)-1:0]      owner
`ifdef FIFO_PUSH_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_last_q, rr_last_d;
    logic [IDX_W-1:0]       winner_s;
    logic                   found_s;
    logic                   can_load_s;
    logic                   accept_s;
    logic                   push_s;

    // Search for the first pending requester after the last winner, wrapping modulo NUM_REQ.
    always_comb begin : rr_search
        int               cand_v;
        logic [IDX_W-1:0] cand_idx;
        winner_s = {IDX_W{1'b0}};
        found_s  = 1'b0;
        cand_v   = 0;
        cand_idx = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_v   = (int'(rr_last_q) + k) % NUM_REQ;
            cand_idx = cand_v[IDX_W-1:0];
            if (!found_s && req_valid[cand_idx]) begin
                found_s  = 1'b1;
                winner_s = cand_idx;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Accept window: grant_out bypasses straight to req_ready so a full stage can refill in the push cycle.
    always_comb begin
        can_load_s = (state_q == ST_EMPTY) || grant_out;
        accept_s   = rst_n && can_load_s && found_s;
        push_s     = (state_q == ST_FULL) && grant_out;
        if (accept_s) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Output-stage FSM next state and datapath load.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (push_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (accept_s) begin
            data_d    = req_data[winner_s*DATA_WIDTH +: DATA_WIDTH];
            owner_d   = winner_s;
            rr_last_d = winner_s;
        end else begin
            data_d    = data_q;
        end
    end

    // State and output-stage registers; reset drops any buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            data_q    <= {DATA_WIDTH{1'b0}};
            owner_q   <= {IDX_W{1'b0}};
            rr_last_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign valid_in = (state_q == ST_FULL);
    assign data_in  = data_q;
    assign owner    = owner_q;

`ifdef FIFO_PUSH_ARB_STATS_EN
    logic [NUM_REQ*CNT_WIDTH-1:0] stat_q, stat_d;

    // Saturating push counter per owner.
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push_s && (owner_q == IDX_W'(i)) &&
                (stat_q[i*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}})) begin
                stat_d[i*CNT_WIDTH +: CNT_WIDTH] = stat_q[i*CNT_WIDTH +: CNT_WIDTH] +
                                                   {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stat_d[i*CNT_WIDTH +: CNT_WIDTH] = stat_q[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= {(NUM_REQ*CNT_WIDTH){1'b0}};
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: vector table plus scoreboard of pushed words.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 17;
    localparam int CW = 4;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N*DW-1:0]    req_data;
    logic [N-1:0]       req_ready;
    logic               grant_out;
    logic               valid_in;
    logic [DW-1:0]      data_in;
    logic [1:0]         owner;
`ifdef FIFO_PUSH_ARB_STATS_EN
    logic [N*CW-1:0]    stat_cnt;
`endif

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_out (grant_out),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .owner     (owner)
`ifdef FIFO_PUSH_ARB_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rv;
        logic         g;
        logic [N-1:0] er;
        logic         ev;
    } vec_t;

    typedef struct {
        logic [1:0]    own;
        logic [DW-1:0] dat;
    } exp_t;

    int            n_checks = 0;
    int            n_errors = 0;
    exp_t          sb[$];
    logic [DW-1:0] reqd [N];
    vec_t          tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: drive, check comb/registered outputs, settle scoreboard.
    task automatic step(input logic [N-1:0] rv, input logic g,
                        input logic [N-1:0] er, input logic ev, input string nm);
        exp_t e;
        @(negedge clk);
        req_valid = rv;
        grant_out = g;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = reqd[i];
        #1;
        chk({nm, " req_ready"}, 32'(req_ready), 32'(er));
        chk({nm, " valid_in"}, 32'(valid_in), 32'(ev));
        if (ev && g) begin
            if (sb.size() == 0) begin
                chk({nm, " sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({nm, " push data"}, 32'(data_in), 32'(e.dat));
                chk({nm, " push owner"}, 32'(owner), 32'(e.own));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                e.own = 2'(i);
                e.dat = reqd[i];
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        grant_out = 1'b1;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            reqd[i] = 17'h00A5 + 17'(i) * 17'h1111;
            req_data[i*DW +: DW] = reqd[i];
        end

        // fairness, wrap/skip, short stall
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1};
        tbl[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1};
        tbl[10] = '{4'b1001, 1'b1, 4'b0001, 1'b1};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[13] = '{4'b0010, 1'b0, 4'b0010, 1'b0};
        tbl[14] = '{4'b0010, 1'b0, 4'b0000, 1'b1};
        tbl[15] = '{4'b0010, 1'b0, 4'b0000, 1'b1};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0};

        // T1: reset with all requesters pending
        #3;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst valid_in", 32'(valid_in), 32'd0);
        chk("rst data_in", 32'(data_in), 32'd0);
        chk("rst owner", 32'(owner), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;

        for (int r = 0; r < 18; r++) begin
            step(tbl[r].rv, tbl[r].g, tbl[r].er, tbl[r].ev, $sformatf("vec%0d", r));
        end

        // T3: backpressure holds the buffered word
        reqd[2] = 17'h1ABCD;
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "bp_load");
        for (int c = 0; c < 5; c++) begin
            step(4'b0100, 1'b0, 4'b0000, 1'b1, $sformatf("bp_stall%0d", c));
            chk("bp data_in", 32'(data_in), 32'h1ABCD);
            chk("bp owner", 32'(owner), 32'd2);
        end
        step(4'b0100, 1'b1, 4'b0100, 1'b1, "bp_push");
        step(4'b0000, 1'b1, 4'b0000, 1'b1, "bp_drain");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "bp_idle");

        // T5: reset while a word is stalled in the output stage
        step(4'b0001, 1'b0, 4'b0001, 1'b0, "mid_load");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, "mid_hold");
        req_valid = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid valid_in", 32'(valid_in), 32'd0);
        chk("mid req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        step(4'b1111, 1'b1, 4'b0001, 1'b0, "post_rst");
        step(4'b0000, 1'b1, 4'b0000, 1'b1, "post_drain");

`ifdef FIFO_PUSH_ARB_STATS_EN
        // T6: saturating counter for requester 1
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("stat rst", 32'(stat_cnt), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(4'b0010, 1'b1, 4'b0010, (c > 0), $sformatf("st%0d", c));
        end
        step(4'b0000, 1'b1, 4'b0000, 1'b1, "st_drain");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "st_idle");
        chk("stat cnt1", 32'(stat_cnt[7:4]), 32'd15);
        chk("stat cnt0", 32'(stat_cnt[3:0]), 32'd0);
        chk("stat cnt2", 32'(stat_cnt[11:8]), 32'd0);
        chk("stat cnt3", 32'(stat_cnt[15:12]), 32'd0);
`endif

        chk("sb leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
